round_robin_arbiter: RTL and testbench

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

---
 rtl/round_robin_arbiter.sv | 160 ++++++++++++++++
 tb/tb_round_robin_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for 2**N level requesters with registered one-hot grant.
// Optional grant timeout compiled in with `define RR_ARBITER_TIMEOUT_EN (uses MAX_HOLD).
module round_robin_arbiter #(
    parameter int N        = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**N-1:0]   req,
    output logic [2**N-1:0]   gnt,
    output logic [N-1:0]      gnt_id,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam int NREQ = 2**N;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("round_robin_arbiter: MAX_HOLD must be at least 1");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef struct packed {
        logic         found;
        logic [N-1:0] idx;
    } pick_t;

    state_t          state, state_nxt;
    logic [N-1:0]    ptr, ptr_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [N-1:0]    gnt_id_nxt;
    logic            gnt_valid_nxt;
    logic            timeout_nxt;

    pick_t           pick_all;
    pick_t           take;
    logic            owner_req;

    // Scan downward from the farthest offset so the nearest requester to start wins.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] mask, input logic [N-1:0] start);
        pick_t        p;
        logic [N-1:0] idx;
        p = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = start + N'(k);
            if (mask[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    assign pick_all  = rr_pick(req, ptr);
    assign owner_req = req[gnt_id];

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    pick_t            pick_other;
    logic             hold_expired;

    // hold_cnt is the number of completed cycles of the current owner before this one.
    assign pick_other   = rr_pick(req & ~gnt, ptr);
    assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        take          = '0;

        case (state)
            IDLE: begin
                if (pick_all.found) begin
                    take = pick_all;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    if (pick_all.found) begin
                        take = pick_all;
                    end else begin
                        state_nxt     = IDLE;
                        gnt_nxt       = '0;
                        gnt_id_nxt    = '0;
                        gnt_valid_nxt = 1'b0;
                    end
                end
`ifdef RR_ARBITER_TIMEOUT_EN
                else if (hold_expired && pick_other.found) begin
                    take        = pick_other;
                    timeout_nxt = 1'b1;
                end
`endif
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
            end
        endcase

        if (take.found) begin
            state_nxt     = GRANT;
            gnt_nxt       = NREQ'(1) << take.idx;
            gnt_id_nxt    = take.idx;
            gnt_valid_nxt = 1'b1;
            ptr_nxt       = take.idx + N'(1);
        end
    end

`ifdef RR_ARBITER_TIMEOUT_EN
    always_comb begin
        hold_cnt_nxt = '0;
        if (!take.found && state == GRANT && owner_req && !hold_expired) begin
            hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed table-driven bench for round_robin_arbiter (N=2, MAX_HOLD=4).
// The timeout sequence follows the RR_ARBITER_TIMEOUT_EN build of the design.
module tb_round_robin_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];

    round_robin_arbiter #(.N(2), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] id);
        vec_t v;
        v.rst = r;
        v.req = rq;
        v.gnt = g;
        v.id  = id;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge, then compare all outputs.
    task automatic step(input string tag, input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] eid, input logic eto);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
        check($sformatf("%s gnt", tag), 32'(gnt), 32'(eg));
        check($sformatf("%s gnt_id", tag), 32'(gnt_id), 32'(eid));
        check($sformatf("%s gnt_valid", tag), 32'(gnt_valid), 32'(eg != 4'b0000));
        check($sformatf("%s timeout", tag), 32'(timeout), 32'(eto));
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // reset with all requesting
        add(1, 4'b1111, 4'b0000, 2'd0);
        add(1, 4'b1111, 4'b0000, 2'd0);
        add(1, 4'b1111, 4'b0000, 2'd0);
        add(0, 4'b1111, 4'b0001, 2'd0);
        // rotation 0,1,2,3,0 with owners dropping after 3 cycles
        add(0, 4'b1111, 4'b0001, 2'd0);
        add(0, 4'b1111, 4'b0001, 2'd0);
        add(0, 4'b1110, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0010, 2'd1);
        add(0, 4'b1111, 4'b0010, 2'd1);
        add(0, 4'b1101, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0100, 2'd2);
        add(0, 4'b1111, 4'b0100, 2'd2);
        add(0, 4'b1011, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b1000, 2'd3);
        add(0, 4'b0111, 4'b0001, 2'd0);
        // idle, grant 2, then wrap of ptr 3 -> 0
        add(0, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(0, 4'b0011, 4'b0001, 2'd0);
        // owner 1 holds against requester 3
        add(0, 4'b0010, 4'b0010, 2'd1);
        add(0, 4'b1010, 4'b0010, 2'd1);
        add(0, 4'b1010, 4'b0010, 2'd1);
        add(0, 4'b1000, 4'b1000, 2'd3);
        add(0, 4'b0010, 4'b0010, 2'd1);
        add(0, 4'b0000, 4'b0000, 2'd0);
        add(0, 4'b0000, 4'b0000, 2'd0);
        // new request on the same edge the owner drops
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(0, 4'b0001, 4'b0001, 2'd0);
        add(0, 4'b1111, 4'b0001, 2'd0);
        add(0, 4'b1110, 4'b0010, 2'd1);
        add(0, 4'b1101, 4'b0100, 2'd2);
        add(0, 4'b0011, 4'b0001, 2'd0);
        // reset mid-grant, ptr after regrant to 2 is 3
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(1, 4'b0100, 4'b0000, 2'd0);
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(0, 4'b1001, 4'b1000, 2'd3);
        // reset restarts arbitration from ptr 0
        add(0, 4'b0100, 4'b0100, 2'd2);
        add(1, 4'b0010, 4'b0000, 2'd0);
        add(0, 4'b1010, 4'b0010, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].id, 1'b0);
        end

        // grant hold limit with two competing requesters
        step("to_rst", 1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("to_hold%0d", i), 0, 4'b0011, 4'b0001, 2'd0, 1'b0);
        end
`ifdef RR_ARBITER_TIMEOUT_EN
        step("to_revoke", 0, 4'b0011, 4'b0010, 2'd1, 1'b1);
        step("to_pulse_end", 0, 4'b0011, 4'b0010, 2'd1, 1'b0);
`else
        step("to_nohold4", 0, 4'b0011, 4'b0001, 2'd0, 1'b0);
        step("to_nohold5", 0, 4'b0011, 4'b0001, 2'd0, 1'b0);
`endif
        // lone owner is never revoked
        for (int i = 0; i < 8; i++) begin
            step($sformatf("to_alone%0d", i), 0, 4'b0001, 4'b0001, 2'd0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
